id_ctrl_stage: RTL and testbench

ID_CTRL_STAGE -- requirements
Module: id_ctrl_stage

---
 rtl/rv_ctrl_pkg.sv | 71 +++++++
 rtl/id_decode.sv | 115 +++++++++++
 rtl/id_ctrl_stage.sv | 85 ++++++++
 tb/tb_id_ctrl_stage.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared decode definitions for the ID control stage: opcodes, ALU codes and the control bundle.
package rv_ctrl_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned ALU_W = 5;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0011;
    localparam logic [3:0] ALU_AND   = 4'b0100;
    localparam logic [3:0] ALU_OR    = 4'b0101;
    localparam logic [3:0] ALU_XOR   = 4'b0110;
    localparam logic [3:0] ALU_COMP  = 4'b1000;
    localparam logic [3:0] ALU_UCOMP = 4'b1001;
    localparam logic [3:0] ALU_SLL   = 4'b1100;
    localparam logic [3:0] ALU_SRL   = 4'b1101;
    localparam logic [3:0] ALU_SRA   = 4'b1110;

    typedef struct packed {
        logic             mem_read;
        logic             mem_write;
        logic             mem_to_reg;
        logic             reg_write;
        logic             alu_src;
        logic             lui;
        logic             auipc;
        logic             jal;
        logic             jalr;
        logic             b_type;
        logic             beq;
        logic             bne;
        logic             blt;
        logic             bge;
        logic             bltu;
        logic             bgeu;
        logic [2:0]       rw_type;
        logic [ALU_W-1:0] alu_ctl;
        logic             illegal;
    } ctrl_t;

    // Base-ISA ALU op for register/immediate arithmetic; alt selects SUB/SRA.
    function automatic logic [3:0] alu_base(input logic [2:0] func3, input logic alt);
        logic [3:0] op;
        case (func3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_COMP;
            3'b011:  op = ALU_UCOMP;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/id_decode.sv
// Combinational RV32I(+M) decoder producing the control bundle and source-register usage.
module id_decode
    import rv_ctrl_pkg::*;
#(
    parameter bit M_EXT = 1'b1
) (
    input  logic [XLEN-1:0] instr,
    output ctrl_t           ctrl,
    output logic            uses_rs1,
    output logic            uses_rs2
);

    logic [6:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       bad;
    logic       unused_fields;

    assign opcode        = instr[6:0];
    assign func3         = instr[14:12];
    assign func7         = instr[31:25];
    assign unused_fields = ^instr[24:7];

    always_comb begin
        ctrl          = '0;
        uses_rs1      = 1'b0;
        uses_rs2      = 1'b0;
        bad           = 1'b0;
        ctrl.rw_type  = func3;
        ctrl.alu_ctl  = {1'b0, ALU_ADD};
        case (opcode)
            OPC_LOAD: begin
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                uses_rs1        = 1'b1;
                bad             = (func3 == 3'b011) || (func3 == 3'b110) || (func3 == 3'b111);
            end
            OPC_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
                bad            = (func3 >= 3'b011);
            end
            OPC_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.lui       = 1'b1;
            end
            OPC_AUIPC: begin
                ctrl.reg_write = 1'b1;
                ctrl.auipc     = 1'b1;
                ctrl.alu_src   = 1'b1;
            end
            OPC_JAL: begin
                ctrl.reg_write = 1'b1;
                ctrl.jal       = 1'b1;
            end
            OPC_JALR: begin
                ctrl.reg_write = 1'b1;
                ctrl.jalr      = 1'b1;
                ctrl.alu_src   = 1'b1;
                uses_rs1       = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl.b_type = 1'b1;
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
                case (func3)
                    3'b000:  begin ctrl.beq  = 1'b1; ctrl.alu_ctl = {1'b0, ALU_SUB};   end
                    3'b001:  begin ctrl.bne  = 1'b1; ctrl.alu_ctl = {1'b0, ALU_SUB};   end
                    3'b100:  begin ctrl.blt  = 1'b1; ctrl.alu_ctl = {1'b0, ALU_COMP};  end
                    3'b101:  begin ctrl.bge  = 1'b1; ctrl.alu_ctl = {1'b0, ALU_COMP};  end
                    3'b110:  begin ctrl.bltu = 1'b1; ctrl.alu_ctl = {1'b0, ALU_UCOMP}; end
                    3'b111:  begin ctrl.bgeu = 1'b1; ctrl.alu_ctl = {1'b0, ALU_UCOMP}; end
                    default: bad = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                uses_rs1       = 1'b1;
                // Upper immediate bits only select SRAI; for other ops they are plain immediate.
                ctrl.alu_ctl   = {1'b0, alu_base(func3, (func3 == 3'b101) && (func7 == F7_ALT))};
                if (func3 == 3'b001) begin
                    bad = (func7 != F7_BASE);
                end else if (func3 == 3'b101) begin
                    bad = (func7 != F7_BASE) && (func7 != F7_ALT);
                end
            end
            OPC_OP: begin
                ctrl.reg_write = 1'b1;
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
                if (func7 == F7_BASE) begin
                    ctrl.alu_ctl = {1'b0, alu_base(func3, 1'b0)};
                end else if ((func7 == F7_ALT) && ((func3 == 3'b000) || (func3 == 3'b101))) begin
                    ctrl.alu_ctl = {1'b0, alu_base(func3, 1'b1)};
                end else if (M_EXT && (func7 == F7_MULDIV)) begin
                    ctrl.alu_ctl = {2'b10, func3};
                end else begin
                    bad = 1'b1;
                end
            end
            default: bad = 1'b1;
        endcase
        // Illegal entries carry no side effects, only the flag.
        if (bad) begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/id_ctrl_stage.sv
// Decode pipeline stage: one-entry register with valid/ready handshake, load-use interlock and flush.
module id_ctrl_stage
    import rv_ctrl_pkg::*;
#(
    parameter bit M_EXT     = 1'b1,
    parameter bit HAZARD_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  instr,
    output logic             out_valid,
    input  logic             out_ready,
    output ctrl_t            out_ctrl,
    output logic [REG_W-1:0] out_rs1,
    output logic [REG_W-1:0] out_rs2,
    output logic [REG_W-1:0] out_rd
);

    ctrl_t            dec_ctrl;
    logic             uses_rs1;
    logic             uses_rs2;
    logic             hazard;
    logic             load;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;

    assign rs1 = instr[19:15];
    assign rs2 = instr[24:20];
    assign rd  = instr[11:7];

    id_decode #(
        .M_EXT (M_EXT)
    ) u_decode (
        .instr    (instr),
        .ctrl     (dec_ctrl),
        .uses_rs1 (uses_rs1),
        .uses_rs2 (uses_rs2)
    );

    // Load-use interlock: the held load's result is not ready for a dependent consumer.
    always_comb begin
        hazard = 1'b0;
        if (HAZARD_EN) begin
            hazard = in_valid && out_valid && out_ctrl.mem_read && (out_rd != '0) &&
                     ((uses_rs1 && (rs1 == out_rd)) || (uses_rs2 && (rs2 == out_rd)));
        end
    end

    assign in_ready = (~out_valid | out_ready) & ~hazard & ~flush;
    assign load     = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
            out_rs1   <= '0;
            out_rs2   <= '0;
            out_rd    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
            out_rs1   <= '0;
            out_rs2   <= '0;
            out_rd    <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_ctrl  <= dec_ctrl;
            out_rs1   <= rs1;
            out_rs2   <= rs2;
            out_rd    <= rd;
        end else if (~out_valid | out_ready) begin
            // Drained or interlocked: insert an empty slot.
            out_valid <= 1'b0;
            out_ctrl  <= '0;
            out_rs1   <= '0;
            out_rs2   <= '0;
            out_rd    <= '0;
        end
    end

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Self-checking bench for id_ctrl_stage: two parameterisations driven with shared stimulus.
module tb_id_ctrl_stage;
    import rv_ctrl_pkg::*;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        flush     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instr     = '0;

    logic        in_ready_v  [2];
    logic        out_valid_v [2];
    ctrl_t       ctrl_v      [2];
    logic [4:0]  rs1_v       [2];
    logic [4:0]  rs2_v       [2];
    logic [4:0]  rd_v        [2];

    int n_tests = 0;
    int n_fail  = 0;

    bit          exp_valid [2];
    logic [31:0] exp_instr [2];

    always #5 clk = ~clk;

    // dut_a: M extension and interlock on; dut_b: both off.
    id_ctrl_stage #(.M_EXT(1'b1), .HAZARD_EN(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_v[0]),
        .instr(instr), .out_valid(out_valid_v[0]), .out_ready(out_ready), .out_ctrl(ctrl_v[0]),
        .out_rs1(rs1_v[0]), .out_rs2(rs2_v[0]), .out_rd(rd_v[0]));

    id_ctrl_stage #(.M_EXT(1'b0), .HAZARD_EN(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_v[1]),
        .instr(instr), .out_valid(out_valid_v[1]), .out_ready(out_ready), .out_ctrl(ctrl_v[1]),
        .out_rs1(rs1_v[1]), .out_rs2(rs2_v[1]), .out_rd(rd_v[1]));

    // Reference decode written from the instruction-set rules.
    function automatic ctrl_t ref_dec(input logic [31:0] ins, input bit m_ext);
        ctrl_t      c;
        logic [4:0] alu_tbl [8];
        logic [2:0] f3;
        logic [6:0] f7;
        bit         ok;
        alu_tbl = '{5'd0, 5'd12, 5'd8, 5'd9, 5'd6, 5'd13, 5'd5, 5'd4};
        f3 = ins[14:12];
        f7 = ins[31:25];
        ok = 1'b1;
        c  = '0;
        c.rw_type = f3;
        case (ins[6:0])
            7'h03: begin
                c.mem_read = 1; c.mem_to_reg = 1; c.reg_write = 1; c.alu_src = 1;
                ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            end
            7'h23: begin c.mem_write = 1; c.alu_src = 1; ok = (f3 < 3'd3); end
            7'h37: begin c.reg_write = 1; c.lui = 1; end
            7'h17: begin c.reg_write = 1; c.auipc = 1; c.alu_src = 1; end
            7'h6f: begin c.reg_write = 1; c.jal = 1; end
            7'h67: begin c.reg_write = 1; c.jalr = 1; c.alu_src = 1; end
            7'h63: begin
                c.b_type = 1;
                ok = (f3 != 3'd2) && (f3 != 3'd3);
                c.beq = (f3 == 3'd0); c.bne = (f3 == 3'd1); c.blt = (f3 == 3'd4);
                c.bge = (f3 == 3'd5); c.bltu = (f3 == 3'd6); c.bgeu = (f3 == 3'd7);
                c.alu_ctl = (f3 < 3'd2) ? 5'd3 : ((f3 < 3'd6) ? 5'd8 : 5'd9);
            end
            7'h13: begin
                c.reg_write = 1; c.alu_src = 1;
                c.alu_ctl = alu_tbl[f3];
                if (f3 == 3'd5 && f7 == 7'h20) c.alu_ctl = 5'd14;
                if (f3 == 3'd1) ok = (f7 == 7'h00);
                if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
            end
            7'h33: begin
                c.reg_write = 1;
                if (f7 == 7'h00) c.alu_ctl = alu_tbl[f3];
                else if (f7 == 7'h20 && f3 == 3'd0) c.alu_ctl = 5'd3;
                else if (f7 == 7'h20 && f3 == 3'd5) c.alu_ctl = 5'd14;
                else if (f7 == 7'h01 && m_ext) c.alu_ctl = 5'd16 + 5'(f3);
                else ok = 1'b0;
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            c = '0;
            c.illegal = 1'b1;
        end
        return c;
    endfunction

    function automatic void ref_uses(input logic [31:0] ins, output bit u1, output bit u2);
        u1 = ins[6:0] inside {7'h03, 7'h13, 7'h33, 7'h23, 7'h63, 7'h67};
        u2 = ins[6:0] inside {7'h33, 7'h23, 7'h63};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [10];
        logic [6:0] op;
        logic [6:0] f7;
        int         k;
        ops = '{7'h03, 7'h23, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h13, 7'h33, 7'h00};
        k   = int'($urandom_range(0, 9));
        op  = ops[k];
        if (k == 9) op = {5'($urandom_range(0, 31)), 2'b11};
        case ($urandom_range(0, 3))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            2:       f7 = 7'h01;
            default: f7 = 7'($urandom);
        endcase
        return {f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), op};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        #2;
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; instr = 32'h002081B3;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (out_valid_v[d] !== 1'b0 || ctrl_v[d] !== '0) begin
                n_fail++; $display("FAIL reset_out[%0d] valid=%b ctrl=%h exp 0/0", d, out_valid_v[d], ctrl_v[d]);
            end
            n_tests++;
            if ({rd_v[d], rs1_v[d], rs2_v[d]} !== 15'd0) begin
                n_fail++; $display("FAIL reset_regs[%0d] got %h exp 0", d, {rd_v[d], rs1_v[d], rs2_v[d]});
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (in_ready_v[d] !== 1'b1) begin
                n_fail++; $display("FAIL reset_in_ready[%0d] got %b exp 1", d, in_ready_v[d]);
            end
        end
    endtask

    task automatic test_add();
        do_reset();
        instr = 32'h002081B3; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n_tests++;
        if (out_valid_v[0] !== 1'b1 || ctrl_v[0].reg_write !== 1'b1 || ctrl_v[0].alu_ctl !== 5'b00000 ||
            rd_v[0] !== 5'd3 || ctrl_v[0].illegal !== 1'b0) begin
            n_fail++; $display("FAIL add got v=%b rw=%b alu=%b rd=%0d ill=%b exp 1/1/00000/3/0",
                out_valid_v[0], ctrl_v[0].reg_write, ctrl_v[0].alu_ctl, rd_v[0], ctrl_v[0].illegal);
        end
        step();
        n_tests++;
        if (out_valid_v[0] !== 1'b0 || ctrl_v[0] !== '0) begin
            n_fail++; $display("FAIL add_drain got v=%b ctrl=%h exp 0/0", out_valid_v[0], ctrl_v[0]);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        instr = 32'h0000A283; in_valid = 1'b1; out_ready = 1'b1;
        step();
        instr = 32'h00528333;
        #1;
        n_tests++;
        if (in_ready_v[0] !== 1'b0 || in_ready_v[1] !== 1'b1) begin
            n_fail++; $display("FAIL lu_in_ready got a=%b b=%b exp 0/1", in_ready_v[0], in_ready_v[1]);
        end
        n_tests++;
        if (out_valid_v[0] !== 1'b1 || ctrl_v[0].mem_read !== 1'b1 || rd_v[0] !== 5'd5) begin
            n_fail++; $display("FAIL lu_load got v=%b mr=%b rd=%0d exp 1/1/5", out_valid_v[0], ctrl_v[0].mem_read, rd_v[0]);
        end
        step();
        n_tests++;
        if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1) begin
            n_fail++; $display("FAIL lu_bubble got v=%b rdy=%b exp 0/1", out_valid_v[0], in_ready_v[0]);
        end
        n_tests++;
        if (out_valid_v[1] !== 1'b1 || rd_v[1] !== 5'd6) begin
            n_fail++; $display("FAIL lu_nohaz got v=%b rd=%0d exp 1/6", out_valid_v[1], rd_v[1]);
        end
        step();
        in_valid = 1'b0;
        n_tests++;
        if (out_valid_v[0] !== 1'b1 || rd_v[0] !== 5'd6 || ctrl_v[0].alu_ctl !== 5'd0) begin
            n_fail++; $display("FAIL lu_add got v=%b rd=%0d alu=%b exp 1/6/00000", out_valid_v[0], rd_v[0], ctrl_v[0].alu_ctl);
        end
    endtask

    task automatic test_mul();
        do_reset();
        instr = 32'h022081B3; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n_tests++;
        if (out_valid_v[0] !== 1'b1 || ctrl_v[0].alu_ctl !== 5'b10000 || ctrl_v[0].illegal !== 1'b0) begin
            n_fail++; $display("FAIL mul_m got v=%b alu=%b ill=%b exp 1/10000/0", out_valid_v[0], ctrl_v[0].alu_ctl, ctrl_v[0].illegal);
        end
        n_tests++;
        if (out_valid_v[1] !== 1'b1 || ctrl_v[1].illegal !== 1'b1 || ctrl_v[1].reg_write !== 1'b0) begin
            n_fail++; $display("FAIL mul_nom got v=%b ill=%b rw=%b exp 1/1/0", out_valid_v[1], ctrl_v[1].illegal, ctrl_v[1].reg_write);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        instr = 32'h0000007F; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (out_valid_v[d] !== 1'b1 || ctrl_v[d].illegal !== 1'b1 ||
                {ctrl_v[d].reg_write, ctrl_v[d].mem_read, ctrl_v[d].mem_write,
                 ctrl_v[d].jal, ctrl_v[d].jalr, ctrl_v[d].b_type} !== 6'b0) begin
                n_fail++; $display("FAIL illegal[%0d] got v=%b ctrl=%h exp valid, illegal only", d, out_valid_v[d], ctrl_v[d]);
            end
        end
    endtask

    task automatic test_stall_flush();
        do_reset();
        instr = 32'h402081B3; in_valid = 1'b1; out_ready = 1'b1;
        step();
        instr = 32'h00310233; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (out_valid_v[0] !== 1'b1 || ctrl_v[0].alu_ctl !== 5'b00011 || in_ready_v[0] !== 1'b0 || rd_v[0] !== 5'd3) begin
                n_fail++; $display("FAIL stall[%0d] got v=%b alu=%b rdy=%b rd=%0d exp 1/00011/0/3",
                    i, out_valid_v[0], ctrl_v[0].alu_ctl, in_ready_v[0], rd_v[0]);
            end
            step();
        end
        flush = 1'b1;
        #1;
        n_tests++;
        if (in_ready_v[0] !== 1'b0) begin
            n_fail++; $display("FAIL flush_ready got %b exp 0", in_ready_v[0]);
        end
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        n_tests++;
        if (out_valid_v[0] !== 1'b0 || ctrl_v[0] !== '0) begin
            n_fail++; $display("FAIL flush_clear got v=%b ctrl=%h exp 0/0", out_valid_v[0], ctrl_v[0]);
        end
        step();
        n_tests++;
        if (out_valid_v[0] !== 1'b0) begin
            n_fail++; $display("FAIL flush_drop got v=%b exp 0", out_valid_v[0]);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        instr = 32'h00208463; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        #1;
        n_tests++;
        if (out_valid_v[0] !== 1'b1 || ctrl_v[0].beq !== 1'b1 || ctrl_v[0].alu_ctl !== 5'b00011) begin
            n_fail++; $display("FAIL beq_held got v=%b beq=%b alu=%b exp 1/1/00011", out_valid_v[0], ctrl_v[0].beq, ctrl_v[0].alu_ctl);
        end
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (out_valid_v[d] !== 1'b0 || ctrl_v[d] !== '0) begin
                n_fail++; $display("FAIL async_rst[%0d] got v=%b ctrl=%h exp 0/0", d, out_valid_v[d], ctrl_v[d]);
            end
        end
        #2;
        rst_n = 1'b1; out_ready = 1'b1;
        step();
        n_tests++;
        if (out_valid_v[0] !== 1'b0) begin
            n_fail++; $display("FAIL async_discard got v=%b exp 0", out_valid_v[0]);
        end
    endtask

    task automatic test_random(input int cycles);
        ctrl_t      ec;
        bit         u1, u2, haz, er, acc, emit;
        logic [4:0] erd;
        do_reset();
        for (int d = 0; d < 2; d++) begin
            exp_valid[d] = 1'b0;
            exp_instr[d] = '0;
        end
        for (int t = 0; t < cycles; t++) begin
            @(negedge clk);
            flush     = ($urandom_range(0, 15) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            instr     = rand_instr();
            #1;
            ref_uses(instr, u1, u2);
            for (int d = 0; d < 2; d++) begin
                ec  = exp_valid[d] ? ref_dec(exp_instr[d], d == 0) : '0;
                erd = exp_instr[d][11:7];
                haz = (d == 0) && in_valid && exp_valid[d] && ec.mem_read && (erd != 5'd0) &&
                      ((u1 && instr[19:15] == erd) || (u2 && instr[24:20] == erd));
                er  = (!exp_valid[d] || out_ready) && !haz && !flush;
                n_tests++;
                if (out_valid_v[d] !== exp_valid[d]) begin
                    n_fail++; $display("FAIL rnd_valid[%0d] t=%0d got %b exp %b", d, t, out_valid_v[d], exp_valid[d]);
                end
                n_tests++;
                if (in_ready_v[d] !== er) begin
                    n_fail++; $display("FAIL rnd_ready[%0d] t=%0d got %b exp %b", d, t, in_ready_v[d], er);
                end
                n_tests++;
                if (ctrl_v[d] !== ec) begin
                    n_fail++; $display("FAIL rnd_ctrl[%0d] t=%0d instr=%h got %h exp %h", d, t, exp_instr[d], ctrl_v[d], ec);
                end
                if (exp_valid[d]) begin
                    n_tests++;
                    if ({rd_v[d], rs1_v[d], rs2_v[d]} !== {erd, exp_instr[d][19:15], exp_instr[d][24:20]}) begin
                        n_fail++; $display("FAIL rnd_regs[%0d] t=%0d got %h exp %h", d, t,
                            {rd_v[d], rs1_v[d], rs2_v[d]}, {erd, exp_instr[d][19:15], exp_instr[d][24:20]});
                    end
                end
                acc  = in_valid && er;
                emit = exp_valid[d] && out_ready;
                if (flush) exp_valid[d] = 1'b0;
                else if (acc) begin
                    exp_valid[d] = 1'b1;
                    exp_instr[d] = instr;
                end else if (emit) exp_valid[d] = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_load_use();
        test_mul();
        test_illegal();
        test_stall_flush();
        test_async_reset();
        test_random(800);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
